// File: rtl/sim_run_controller.sv
// Simulation run controller: staggered per-channel reset release, done/error collection,
// cycle timeout and a registered verdict. Define SIM_RUN_CTRL_FINISH_EN to print the verdict and end the sim.
module sim_run_controller #(
  parameter int N              = 2,
  parameter int RESET_CYCLES   = 58,
  parameter int STAGGER        = 4,
  parameter int TIMEOUT_CYCLES = 580000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [N-1:0]         dut_reset,
  input  logic [N-1:0]         done_in,
  input  logic [N-1:0]         error_in,
  output logic [N-1:0]         done_mask,
  output logic                 running,
  output logic                 finished,
  output logic                 timed_out,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  // state      | meaning
  // ST_HOLD    | all channels held in reset for RESET_CYCLES
  // ST_RELEASE | channels released one by one, STAGGER cycles apart
  // ST_RUN     | all released; waiting for completion or timeout
  // ST_DONE    | verdict frozen until reset
  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN, ST_DONE} state_t;

  localparam logic        ALL_AT_ONCE = (N == 1) || (STAGGER == 0);
  localparam logic [31:0] HOLD_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] REL_LAST    = ALL_AT_ONCE ? 32'd0 : 32'((N - 1) * STAGGER - 1);

  state_t                 state_q;
  logic [31:0]            phase_q;
  logic [N-1:0]           dut_reset_q;
  logic [N-1:0]           done_mask_q;
  logic                   error_seen_q;
  logic                   running_q;
  logic                   finished_q;
  logic                   timed_out_q;
  logic                   pass_q;
  logic [CNT_WIDTH-1:0]   cycle_count_q;

  logic [N-1:0]           done_s;
  logic [N-1:0]           err_s;
  logic                   complete;
  logic                   tmo;

  // Inputs from a channel still in reset are ignored.
  always_comb begin
    done_s   = done_in & ~dut_reset_q;
    err_s    = error_in & ~dut_reset_q;
    complete = &(done_mask_q | done_s);
    tmo      = (cycle_count_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      phase_q       <= '0;
      dut_reset_q   <= '1;
      done_mask_q   <= '0;
      error_seen_q  <= 1'b0;
      running_q     <= 1'b0;
      finished_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      pass_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (phase_q == HOLD_LAST) begin
            phase_q        <= '0;
            dut_reset_q[0] <= 1'b0;
            running_q      <= 1'b1;
            if (ALL_AT_ONCE) begin
              dut_reset_q <= '0;
              state_q     <= ST_RUN;
            end else begin
              state_q     <= ST_RELEASE;
            end
          end else begin
            phase_q <= phase_q + 32'd1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          cycle_count_q <= cycle_count_q + 1'b1;
          done_mask_q   <= done_mask_q | done_s;
          if (|err_s) error_seen_q <= 1'b1;
          if (state_q == ST_RELEASE) begin
            phase_q <= phase_q + 32'd1;
            for (int i = 1; i < N; i++) begin
              if (phase_q == 32'(i * STAGGER - 1)) dut_reset_q[i] <= 1'b0;
            end
            if (phase_q == REL_LAST) state_q <= ST_RUN;
          end
          // Completion takes priority over a timeout landing on the same cycle.
          if (complete) begin
            state_q     <= ST_DONE;
            dut_reset_q <= '0;
            running_q   <= 1'b0;
            finished_q  <= 1'b1;
            pass_q      <= !(error_seen_q || (|err_s));
          end else if (tmo) begin
            state_q     <= ST_DONE;
            dut_reset_q <= '0;
            running_q   <= 1'b0;
            finished_q  <= 1'b1;
            timed_out_q <= 1'b1;
            pass_q      <= 1'b0;
          end
        end
        ST_DONE: ;
        default: state_q <= ST_HOLD;
      endcase
    end
  end

`ifdef SIM_RUN_CTRL_FINISH_EN
  logic announced_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      announced_q <= 1'b0;
    end else if (finished_q && !announced_q) begin
      announced_q <= 1'b1;
      $display("sim_run_controller: %s cycle_count=%0d done_mask=%b",
               timed_out_q ? "TIMEOUT" : (pass_q ? "PASS" : "FAIL"),
               cycle_count_q, done_mask_q);
    end else if (announced_q) begin
      $finish;
    end
  end
`endif

  assign dut_reset   = dut_reset_q;
  assign done_mask   = done_mask_q;
  assign running     = running_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign pass        = pass_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller with N=2, RESET_CYCLES=10, STAGGER=3, TIMEOUT_CYCLES=100.
module tb_sim_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dut_reset;
  logic [1:0]  done_in;
  logic [1:0]  error_in;
  logic [1:0]  done_mask;
  logic        running;
  logic        finished;
  logic        timed_out;
  logic        pass;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  sim_run_controller #(
    .N(2), .RESET_CYCLES(10), .STAGGER(3), .TIMEOUT_CYCLES(100), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .done_in(done_in),
    .error_in(error_in), .done_mask(done_mask), .running(running),
    .finished(finished), .timed_out(timed_out), .pass(pass),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_count(input string tag, input int v);
    for (int k = 0; k < 300 && cycle_count != 16'(v); k++) step(1);
    check(tag, 32'(cycle_count), 32'(v));
  endtask

  task automatic do_reset();
    done_in  = 2'b00;
    error_in = 2'b00;
    reset    = 1'b1;
    step(5);
    reset    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    done_in  = 2'b00;
    error_in = 2'b00;
    step(2);
    check("rst_dut_reset", 32'(dut_reset), 32'h3);
    check("rst_done_mask", 32'(done_mask), 0);
    check("rst_running",   32'(running),   0);
    check("rst_finished",  32'(finished),  0);
    check("rst_timed_out", 32'(timed_out), 0);
    check("rst_pass",      32'(pass),      0);
    check("rst_count",     32'(cycle_count), 0);

    // Release timing
    do_reset();
    step(9);
    check("rel_e9_dut_reset", 32'(dut_reset), 32'h3);
    check("rel_e9_running",   32'(running),   0);
    step(1);
    check("rel_e10_dut_reset", 32'(dut_reset), 32'h2);
    check("rel_e10_running",   32'(running),   1);
    check("rel_e10_count",     32'(cycle_count), 0);
    step(2);
    check("rel_e12_dut_reset", 32'(dut_reset), 32'h2);
    step(1);
    check("rel_e13_dut_reset", 32'(dut_reset), 32'h0);
    check("rel_e13_count",     32'(cycle_count), 3);

    // Normal pass
    wait_count("pass_wait20", 20);
    done_in = 2'b01; step(1); done_in = 2'b00;
    check("pass_mask_partial", 32'(done_mask), 32'h1);
    check("pass_not_finished", 32'(finished), 0);
    wait_count("pass_wait30", 30);
    done_in = 2'b10; step(1); done_in = 2'b00;
    check("pass_finished",  32'(finished),  1);
    check("pass_pass",      32'(pass),      1);
    check("pass_timed_out", 32'(timed_out), 0);
    check("pass_mask",      32'(done_mask), 32'h3);
    check("pass_count",     32'(cycle_count), 31);
    check("pass_running",   32'(running),   0);
    step(5);
    check("pass_count_frozen", 32'(cycle_count), 31);
    check("pass_dut_reset",    32'(dut_reset),   0);

    // Error fail
    do_reset();
    wait_count("err_wait25", 25);
    error_in = 2'b10; step(1); error_in = 2'b00;
    check("err_running", 32'(running), 1);
    wait_count("err_wait40", 40);
    done_in = 2'b11; step(1); done_in = 2'b00;
    check("err_finished",  32'(finished),  1);
    check("err_pass",      32'(pass),      0);
    check("err_timed_out", 32'(timed_out), 0);
    check("err_count",     32'(cycle_count), 41);

    // Gated input then timeout
    do_reset();
    step(10);
    done_in = 2'b10; step(2); done_in = 2'b00;
    check("gate_dut_reset", 32'(dut_reset), 32'h2);
    check("gate_mask",      32'(done_mask), 0);
    wait_count("gate_wait50", 50);
    done_in = 2'b01; step(1); done_in = 2'b00;
    wait_count("gate_wait99", 99);
    check("gate_not_finished", 32'(finished), 0);
    step(1);
    check("tmo_finished",  32'(finished),  1);
    check("tmo_timed_out", 32'(timed_out), 1);
    check("tmo_pass",      32'(pass),      0);
    check("tmo_count",     32'(cycle_count), 100);
    check("tmo_mask",      32'(done_mask), 32'h1);

    // Completion and timeout on the same cycle
    do_reset();
    wait_count("tie_wait10", 10);
    done_in = 2'b01; step(1); done_in = 2'b00;
    wait_count("tie_wait99", 99);
    done_in = 2'b10; step(1); done_in = 2'b00;
    check("tie_finished",  32'(finished),  1);
    check("tie_timed_out", 32'(timed_out), 0);
    check("tie_pass",      32'(pass),      1);
    check("tie_count",     32'(cycle_count), 100);

    // Mid-run reset restarts the sequence
    do_reset();
    wait_count("mid_wait40", 40);
    reset = 1'b1; step(1); reset = 1'b0;
    check("mid_dut_reset", 32'(dut_reset), 32'h3);
    check("mid_count",     32'(cycle_count), 0);
    check("mid_running",   32'(running),   0);
    check("mid_finished",  32'(finished),  0);
    step(9);
    check("mid_e9_dut_reset", 32'(dut_reset), 32'h3);
    step(1);
    check("mid_e10_dut_reset", 32'(dut_reset), 32'h2);
    check("mid_e10_running",   32'(running),   1);
    step(3);
    check("mid_e13_dut_reset", 32'(dut_reset), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
